// File: rtl/core_ctrl.sv
// Sequencer for one core's MAC datapath: issues weight/activation reads for an
// N x K matrix-vector tile, pipelines MAC strobes and writes each result out.
module core_ctrl #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned MAC_LAT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  cfg_k,
    input  logic [CNT_W-1:0]  cfg_n,
    input  logic [ADDR_W-1:0] cfg_wbase,
    input  logic [ADDR_W-1:0] cfg_abase,
    input  logic [ADDR_W-1:0] cfg_obase,
    output logic              busy,
    output logic              done,
    output logic              wmem_ren,
    output logic [ADDR_W-1:0] wmem_raddr,
    output logic              amem_ren,
    output logic [ADDR_W-1:0] amem_raddr,
    output logic              mac_en,
    output logic              mac_clr,
    output logic              omem_wen,
    output logic [ADDR_W-1:0] omem_waddr,
    input  logic              out_ready
);

    localparam int unsigned LAT = MAC_LAT;
    localparam int unsigned DW  = $clog2(MAC_LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  k;
    logic [CNT_W-1:0]  n;
    logic [CNT_W-1:0]  kk;
    logic [CNT_W-1:0]  nn;
    logic [ADDR_W-1:0] wbase;
    logic [ADDR_W-1:0] abase;
    logic [ADDR_W-1:0] obase;
    logic [ADDR_W-1:0] wptr;
    logic [DW-1:0]     dcnt;
    logic              issue_first;
    logic [LAT-1:0]    en_sr;
    logic [LAT-1:0]    clr_sr;

    assign amem_ren = wmem_ren;
    assign mac_en   = en_sr[LAT-1];
    assign mac_clr  = clr_sr[LAT-1];

    // wptr always holds the running index of the next weight read to issue
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            k           <= '0;
            n           <= '0;
            kk          <= '0;
            nn          <= '0;
            wbase       <= '0;
            abase       <= '0;
            obase       <= '0;
            wptr        <= '0;
            dcnt        <= '0;
            issue_first <= 1'b0;
            en_sr       <= '0;
            clr_sr      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            wmem_ren    <= 1'b0;
            wmem_raddr  <= '0;
            amem_raddr  <= '0;
            omem_wen    <= 1'b0;
            omem_waddr  <= '0;
        end else begin
            en_sr  <= (en_sr << 1) | LAT'(wmem_ren);
            clr_sr <= (clr_sr << 1) | LAT'(issue_first);

            case (state)
                S_IDLE: begin
                    if (start) begin
                        kk    <= cfg_k;
                        nn    <= cfg_n;
                        wbase <= cfg_wbase;
                        abase <= cfg_abase;
                        obase <= cfg_obase;
                        k     <= '0;
                        n     <= '0;
                        busy  <= 1'b1;
                        if (cfg_k == '0 || cfg_n == '0) begin
                            wptr  <= '0;
                            state <= S_DONE;
                        end else begin
                            wptr        <= ADDR_W'(1);
                            wmem_ren    <= 1'b1;
                            issue_first <= 1'b1;
                            wmem_raddr  <= cfg_wbase;
                            amem_raddr  <= cfg_abase;
                            state       <= S_ISSUE;
                        end
                    end
                end

                S_ISSUE: begin
                    issue_first <= 1'b0;
                    if (k == kk - CNT_W'(1)) begin
                        k        <= '0;
                        dcnt     <= '0;
                        wmem_ren <= 1'b0;
                        state    <= S_DRAIN;
                    end else begin
                        k          <= k + CNT_W'(1);
                        wptr       <= wptr + ADDR_W'(1);
                        wmem_raddr <= wbase + wptr;
                        amem_raddr <= abase + ADDR_W'(k + CNT_W'(1));
                    end
                end

                S_DRAIN: begin
                    if (dcnt == DW'(MAC_LAT - 1)) begin
                        omem_wen   <= 1'b1;
                        omem_waddr <= obase + ADDR_W'(n);
                        state      <= S_WRITE;
                    end else begin
                        dcnt <= dcnt + DW'(1);
                    end
                end

                S_WRITE: begin
                    if (out_ready) begin
                        omem_wen <= 1'b0;
                        if (n == nn - CNT_W'(1)) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            n           <= n + CNT_W'(1);
                            wptr        <= wptr + ADDR_W'(1);
                            wmem_ren    <= 1'b1;
                            issue_first <= 1'b1;
                            wmem_raddr  <= wbase + wptr;
                            amem_raddr  <= abase;
                            state       <= S_ISSUE;
                        end
                    end
                end

                // A degenerate launch enters with done low and spends one cycle
                // here before pulsing done.
                S_DONE: begin
                    if (!done) begin
                        done <= 1'b1;
                    end else begin
                        done  <= 1'b0;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_core_ctrl.sv
// Bench for core_ctrl: directed vector table, reset corner case and randomized
// jobs, all checked against an event-level model of the tiled MAC sequence.
module tb_core_ctrl;

    localparam int unsigned ADDR_W  = 10;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned MAC_LAT = 3;
    localparam int          AMOD    = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [CNT_W-1:0]  cfg_k;
    logic [CNT_W-1:0]  cfg_n;
    logic [ADDR_W-1:0] cfg_wbase;
    logic [ADDR_W-1:0] cfg_abase;
    logic [ADDR_W-1:0] cfg_obase;
    logic              busy;
    logic              done;
    logic              wmem_ren;
    logic [ADDR_W-1:0] wmem_raddr;
    logic              amem_ren;
    logic [ADDR_W-1:0] amem_raddr;
    logic              mac_en;
    logic              mac_clr;
    logic              omem_wen;
    logic [ADDR_W-1:0] omem_waddr;
    logic              out_ready;

    int vectors = 0;
    int errors  = 0;

    core_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .MAC_LAT(MAC_LAT)) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_k(cfg_k), .cfg_n(cfg_n),
        .cfg_wbase(cfg_wbase), .cfg_abase(cfg_abase), .cfg_obase(cfg_obase),
        .busy(busy), .done(done),
        .wmem_ren(wmem_ren), .wmem_raddr(wmem_raddr),
        .amem_ren(amem_ren), .amem_raddr(amem_raddr),
        .mac_en(mac_en), .mac_clr(mac_clr),
        .omem_wen(omem_wen), .omem_waddr(omem_waddr),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_ren"}, {wmem_ren, amem_ren}, 0);
        chk({tag, "_raddr"}, {wmem_raddr, amem_raddr}, 0);
        chk({tag, "_mac"}, {mac_en, mac_clr}, 0);
        chk({tag, "_wen"}, omem_wen, 0);
        chk({tag, "_waddr"}, omem_waddr, 0);
    endtask

    // One job from start pulse to return to IDLE; the model is the expected
    // sequence of read/MAC/write events and the closed-form done cycle.
    task automatic run_job(input int k, input int n, input int w, input int a, input int o,
                           input int stall_first, input bit rand_rdy, input bit scramble,
                           output int r_reads, output int r_lw, output int r_la,
                           output int r_lo, output int r_clr, output int r_done);
        int idx = 0, en_idx = 0, wr_idx = 0, stalls = 0, kd, exp_done;
        int ren_q[$];
        bit seen_done = 0;
        bit rdy;
        kd = (k == 0) ? 1 : k;
        r_lw = 0; r_la = 0; r_lo = 0; r_clr = 0; r_done = 0;
        @(negedge clk);
        cfg_k = CNT_W'(k); cfg_n = CNT_W'(n);
        cfg_wbase = ADDR_W'(w); cfg_abase = ADDR_W'(a); cfg_obase = ADDR_W'(o);
        start = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc <= 3000; cyc++) begin
            if (seen_done) begin
                chk("busy_after_done", busy, 0);
                chk("done_width", done, 0);
                break;
            end
            chk("busy", busy, 1);
            if (wmem_ren) begin
                chk("wraddr", wmem_raddr, (w + idx) % AMOD);
                chk("araddr", amem_raddr, (a + idx % kd) % AMOD);
                chk("amem_ren", amem_ren, 1);
                chk("ren_during_write", omem_wen, 0);
                ren_q.push_back(cyc);
                r_lw = int'(wmem_raddr);
                r_la = int'(amem_raddr);
                idx++;
            end
            if (mac_en) begin
                if (ren_q.size() == 0) chk("mac_en_spurious", mac_en, 0);
                else begin
                    chk("mac_en_lat", cyc - ren_q.pop_front(), MAC_LAT);
                    chk("mac_clr", mac_clr, (en_idx % kd) == 0);
                    en_idx++;
                end
                if (mac_clr) r_clr++;
            end else begin
                chk("mac_clr_idle", mac_clr, 0);
            end
            if (done) begin
                exp_done = (k == 0 || n == 0) ? 2 : 1 + n * (k + MAC_LAT + 1) + stalls;
                chk("done_cycle", cyc, exp_done);
                seen_done = 1;
                r_done = cyc;
            end
            if (omem_wen) begin
                chk("waddr", omem_waddr, (o + wr_idx) % AMOD);
                if (wr_idx == 0 && stalls < stall_first) rdy = 1'b0;
                else if (rand_rdy) rdy = 1'($urandom_range(0, 1));
                else rdy = 1'b1;
                out_ready = rdy;
                if (rdy) begin
                    r_lo = int'(omem_waddr);
                    wr_idx++;
                end else begin
                    stalls++;
                end
            end else begin
                out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (scramble && !seen_done) begin
                cfg_k = CNT_W'($urandom); cfg_n = CNT_W'($urandom);
                cfg_wbase = ADDR_W'($urandom); cfg_abase = ADDR_W'($urandom);
                cfg_obase = ADDR_W'($urandom);
                start = 1'($urandom_range(0, 1));
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        out_ready = 1'b1;
        if (!seen_done) begin
            vectors++;
            errors++;
            $display("FAIL done_timeout: no done within budget (k=%0d n=%0d)", k, n);
        end
        chk("reads_total", idx, n * k);
        chk("mac_en_total", en_idx, n * k);
        chk("writes_total", wr_idx, (k == 0) ? 0 : n);
        r_reads = idx;
    endtask

    typedef struct {
        int k, n, w, a, o, stall;
        bit scr;
        int reads, lw, la, lo, clr, done_c;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int rr, rlw, rla, rlo, rclr, rdone;
        rst = 1'b1; start = 1'b0; out_ready = 1'b1;
        cfg_k = '0; cfg_n = '0; cfg_wbase = '0; cfg_abase = '0; cfg_obase = '0;

        //          k  n  w      a      o      stl scr reads lw     la     lo     clr done
        tbl[0] = '{4, 2, 'h010, 'h020, 'h030, 0, 0, 8, 'h017, 'h023, 'h031, 2, 17};
        tbl[1] = '{4, 2, 'h010, 'h020, 'h030, 5, 0, 8, 'h017, 'h023, 'h031, 2, 22};
        tbl[2] = '{0, 3, 'h010, 'h020, 'h030, 0, 0, 0, 0,     0,     0,     0, 2};
        tbl[3] = '{5, 0, 'h010, 'h020, 'h030, 0, 0, 0, 0,     0,     0,     0, 2};
        tbl[4] = '{4, 1, 'h3FE, 'h100, 'h200, 0, 0, 4, 'h001, 'h103, 'h200, 1, 9};
        tbl[5] = '{1, 1, 'h005, 'h006, 'h007, 0, 0, 1, 'h005, 'h006, 'h007, 1, 6};
        tbl[6] = '{3, 3, 'h3FF, 'h3FE, 'h3FE, 0, 0, 9, 'h007, 'h000, 'h000, 3, 22};
        tbl[7] = '{4, 2, 'h010, 'h020, 'h030, 0, 1, 8, 'h017, 'h023, 'h031, 2, 17};

        #1;
        chk_all_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_all_zero("idle");

        for (int i = 0; i < 8; i++) begin
            run_job(tbl[i].k, tbl[i].n, tbl[i].w, tbl[i].a, tbl[i].o, tbl[i].stall, 0, tbl[i].scr,
                    rr, rlw, rla, rlo, rclr, rdone);
            chk($sformatf("t%0d_reads", i), rr, tbl[i].reads);
            chk($sformatf("t%0d_last_w", i), rlw, tbl[i].lw);
            chk($sformatf("t%0d_last_a", i), rla, tbl[i].la);
            chk($sformatf("t%0d_last_o", i), rlo, tbl[i].lo);
            chk($sformatf("t%0d_clr", i), rclr, tbl[i].clr);
            chk($sformatf("t%0d_done", i), rdone, tbl[i].done_c);
        end

        // Asynchronous reset while issuing k=2 of the first output
        @(negedge clk);
        cfg_k = 8'd4; cfg_n = 8'd2; cfg_wbase = 10'h010; cfg_abase = 10'h020; cfg_obase = 10'h030;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_rst_waddr", wmem_raddr, 'h012);
        chk("pre_rst_aaddr", amem_raddr, 'h022);
        #2 rst = 1'b1;
        #1 chk_all_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("post_rst_quiet", {mac_en, mac_clr, wmem_ren, omem_wen, busy, done}, 0);
        end
        run_job(4, 2, 'h010, 'h020, 'h030, 0, 0, 0, rr, rlw, rla, rlo, rclr, rdone);
        chk("post_rst_done", rdone, 17);
        chk("post_rst_last_w", rlw, 'h017);

        for (int i = 0; i < 24; i++) begin
            int rk, rn;
            rk = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 6));
            rn = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 4));
            run_job(rk, rn, int'($urandom_range(0, AMOD - 1)), int'($urandom_range(0, AMOD - 1)),
                    int'($urandom_range(0, AMOD - 1)), int'($urandom_range(0, 3)), 1, 1,
                    rr, rlw, rla, rlo, rclr, rdone);
            chk("rand_clr", rclr, (rk == 0) ? 0 : rn);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/core_ctrl.md
Name: core_ctrl

Overview:
Sequencer for one compute core's MAC datapath. It runs a tiled matrix-vector product (N outputs, K-deep reduction) by issuing weight and activation SRAM reads and pipelining MAC enable and clear strobes. It writes each accumulated result to the output buffer with backpressure. It sits between the top-level scheduler (start/done) and the core's SRAMs and MAC/accumulator.

Parameters:
ADDR_W, 10, SRAM address width; all address arithmetic wraps modulo 2^ADDR_W
CNT_W, 8, width of cfg_k / cfg_n and internal loop counters
MAC_LAT, 3, cycles from read-enable to operand arrival at MAC (>=1)

Ports:
clk  in  1  core clock
rst  in  1  asynchronous, active-high reset
start  in  1  launch pulse; sampled only in IDLE
cfg_k  in  CNT_W  reduction length K
cfg_n  in  CNT_W  number of outputs N
cfg_wbase  in  ADDR_W  weight base address
cfg_abase  in  ADDR_W  activation base address
cfg_obase  in  ADDR_W  output base address
busy  out  1  state != IDLE
done  out  1  one-cycle completion pulse
wmem_ren  out  1  weight SRAM read enable
wmem_raddr  out  ADDR_W  weight read address
amem_ren  out  1  activation SRAM read enable
amem_raddr  out  ADDR_W  activation read address
mac_en  out  1  MAC accumulate enable (ren delayed MAC_LAT)
mac_clr  out  1  first-term flag: accumulator loads instead of adds (delayed MAC_LAT)
omem_wen  out  1  output write request
omem_waddr  out  ADDR_W  output write address
out_ready  in  1  output buffer accepts write when high with omem_wen

Behaviour:
- Reset (async, any time, including mid-run): state IDLE; all counters, pointers and the MAC_LAT delay line cleared. All outputs 0. No partial writes are issued after reset release.
- States: IDLE, ISSUE, DRAIN, WRITE, DONE.
- IDLE: on start=1, latch all cfg_* and clear k, n and wptr. If cfg_k==0 or cfg_n==0, go to DONE; else go to ISSUE. start while busy is ignored.
- ISSUE: one read per cycle, k = 0..K-1.
  - wmem_ren=amem_ren=1.
  - wmem_raddr = wbase + wptr, where wptr is a running pointer (n*K + k) incremented each issue and never reset between outputs.
  - amem_raddr = abase + k.
  - After the k=K-1 issue: k cleared, go to DRAIN.
- Delay line: mac_en is wmem_ren delayed exactly MAC_LAT cycles. mac_clr is (ISSUE && k==0) delayed exactly MAC_LAT cycles. Both are registered shift registers.
- DRAIN: lasts MAC_LAT cycles (counter), then go to WRITE. The last mac_en pulse coincides with the final DRAIN cycle.
- WRITE: omem_wen=1, omem_waddr = obase + n.
  - Hold until out_ready=1; the handshake completes in that cycle.
  - On handshake: if n==N-1, go to DONE; else n++ and go to ISSUE.
  - Address and wen stay stable while stalled.
- DONE: done=1 for one cycle, busy=1, then go to IDLE.
- Timing with out_ready=1 and start sampled at edge 0: each output costs K+MAC_LAT+1 cycles, and done is high in cycle 1 + N*(K+MAC_LAT+1).
- Outputs are driven from state and registers only, with no combinational path from start. out_ready→omem_wen is not combinational.
- Counter widths: k and n are CNT_W; wptr is ADDR_W and wraps silently.

Test Plan:
- K=4, N=2, MAC_LAT=3, bases w=0x010, a=0x020, o=0x030, out_ready=1 → weight addrs 0x010..0x017 in order, act addrs 0x020..0x023 twice. Writes to 0x030 then 0x031. mac_en pulses in 8 cycles total, mac_clr on the 1st and 5th. done in cycle 17, busy low in cycle 18.
- Same config, out_ready held low 5 cycles at the first WRITE → omem_wen/omem_waddr=0x030 held stable for 6 cycles, no extra reads issued, done delayed to cycle 22.
- cfg_k=0, N=3 (and separately K=5, N=0) → no ren/wen ever, done in cycle 2, busy high cycles 1–2 only.
- start re-pulsed during ISSUE, and cfg_* changed mid-run → ignored; addresses follow the originally latched config.
- rst asserted asynchronously mid-ISSUE (k=2) → all outputs 0 immediately, state IDLE. No mac_en emerges from the delay line after release, and a fresh start runs correctly.
- wbase=0x3FE, K=4, N=1 (ADDR_W=10) → weight addrs 0x3FE, 0x3FF, 0x000, 0x001 (wrap); done in cycle 9.
